digital_clock_top: RTL and testbench

- Top level of a 24-hour digital clock (HH:MM) for a 4-digit multiplexed common-anode 7-segment display.
- Structure, all inside this block:
  - Seconds prescaler from the system clock.
  - Hour and minute BCD counters.
  - Button synchronisers, debouncers and edge detectors for time setting.
  - Display scan multiplexer.
  - Segment decoder.

---
 rtl/digital_clock_top.sv | 266 ++++++++++++++++++++++++++
 tb/tb_digital_clock_top.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_clock_top.sv
// ---------------------------------------------------------------------------
// digital_clock_top
//
// 24-hour HH:MM clock driving a 4-digit multiplexed common-anode 7-segment
// display. Contains the seconds prescaler, BCD time counters, button
// synchronisers/debouncers/edge detectors, scan multiplexer and segment
// decoder.
//
// Ports:
//   clk_i       in   1  system clock, rising edge
//   btn_i       in   4  [3] async active-high reset, [2] set-mode level,
//                       [1] hour increment, [0] minute increment
//   led7_an_o   out  4  digit anodes, active-low
//                       [3]=hour tens [2]=hour ones [1]=minute tens
//                       [0]=minute ones
//   led7_seg_o  out  8  segments, active-low, [7:1]=a..g, [0]=dp
//
// Button handshake: there is no valid/ready pair here. A debounced rising
// edge on btn_i[1]/btn_i[0] is a single-cycle request that is consumed in
// the same cycle when set mode is active and dropped otherwise.
// ---------------------------------------------------------------------------
module digital_clock_top #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REFRESH_CYCLES  = 50_000
) (
    input  logic       clk_i,
    input  logic [3:0] btn_i,
    output logic [3:0] led7_an_o,
    output logic [7:0] led7_seg_o
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_CYCLES - 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);

    logic rst;
    assign rst = btn_i[3];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]          sync1_q, sync1_d;
    logic [2:0]          sync2_q, sync2_d;
    logic [2:0]          deb_q, deb_d;
    logic [2:0]          deb_prev_q, deb_prev_d;
    logic [2:0][DW-1:0]  dcnt_q, dcnt_d;

    logic [PW-1:0]       pre_q, pre_d;
    logic [2:0]          sec_t_q, sec_t_d;
    logic [3:0]          sec_o_q, sec_o_d;
    logic [2:0]          min_t_q, min_t_d;
    logic [3:0]          min_o_q, min_o_d;
    logic [1:0]          hr_t_q, hr_t_d;
    logic [3:0]          hr_o_q, hr_o_d;
    logic                colon_q, colon_d;

    logic [RW-1:0]       ref_q, ref_d;
    logic [1:0]          idx_q, idx_d;
    logic [3:0]          an_q, an_d;
    logic [7:0]          seg_q, seg_d;

    // ------------------------------------------------------------------
    // Button path: synchronise, debounce, detect rising edges
    // ------------------------------------------------------------------
    logic [2:0] rise;
    logic       set_mode;
    logic       inc_hr;
    logic       inc_min;

    always_comb begin
        sync1_d    = btn_i[2:0];
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        dcnt_d     = dcnt_q;
        deb_prev_d = deb_q;
        // The counter only runs while the synchronised level disagrees with
        // the accepted level; any agreeing sample restarts the count.
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DEB_MAX) begin
                deb_d[i]  = sync2_q[i];
                dcnt_d[i] = '0;
            end else begin
                dcnt_d[i] = dcnt_q[i] + DW'(1);
            end
        end
    end

    assign rise     = deb_q & ~deb_prev_q;
    assign set_mode = deb_q[2];
    assign inc_hr   = set_mode & rise[1];
    assign inc_min  = set_mode & rise[0];

    // ------------------------------------------------------------------
    // Prescaler and BCD time counters
    // ------------------------------------------------------------------
    logic sec_tick;
    logic sec_at_59;
    logic min_at_59;
    logic bump_min;
    logic bump_hr;

    assign sec_at_59 = (sec_t_q == 3'd5) && (sec_o_q == 4'd9);
    assign min_at_59 = (min_t_q == 3'd5) && (min_o_q == 4'd9);
    assign sec_tick  = !set_mode && (pre_q == PRE_MAX);

    // In set mode the buttons drive minutes/hours directly and there is no
    // minute-to-hour carry; in run mode the carries come from the seconds.
    assign bump_min = set_mode ? inc_min : (sec_tick && sec_at_59);
    assign bump_hr  = set_mode ? inc_hr  : (bump_min && min_at_59);

    always_comb begin
        pre_d   = pre_q;
        sec_t_d = sec_t_q;
        sec_o_d = sec_o_q;
        min_t_d = min_t_q;
        min_o_d = min_o_q;
        hr_t_d  = hr_t_q;
        hr_o_d  = hr_o_q;
        colon_d = colon_q;

        if (set_mode) begin
            // Holding these at zero makes leaving set mode start at :00.
            pre_d   = '0;
            sec_t_d = 3'd0;
            sec_o_d = 4'd0;
            colon_d = 1'b1;
        end else if (sec_tick) begin
            pre_d   = '0;
            colon_d = ~colon_q;
            if (sec_o_q == 4'd9) begin
                sec_o_d = 4'd0;
                sec_t_d = (sec_t_q == 3'd5) ? 3'd0 : sec_t_q + 3'd1;
            end else begin
                sec_o_d = sec_o_q + 4'd1;
            end
        end else begin
            pre_d = pre_q + PW'(1);
        end

        if (bump_min) begin
            if (min_o_q == 4'd9) begin
                min_o_d = 4'd0;
                min_t_d = (min_t_q == 3'd5) ? 3'd0 : min_t_q + 3'd1;
            end else begin
                min_o_d = min_o_q + 4'd1;
            end
        end

        if (bump_hr) begin
            if (hr_t_q == 2'd2 && hr_o_q == 4'd3) begin
                hr_t_d = 2'd0;
                hr_o_d = 4'd0;
            end else if (hr_o_q == 4'd9) begin
                hr_t_d = hr_t_q + 2'd1;
                hr_o_d = 4'd0;
            end else begin
                hr_o_d = hr_o_q + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan multiplexer and segment decoder
    // ------------------------------------------------------------------
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h03;
            4'd1:    s = 8'h9F;
            4'd2:    s = 8'h25;
            4'd3:    s = 8'h0D;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h49;
            4'd6:    s = 8'h41;
            4'd7:    s = 8'h1F;
            4'd8:    s = 8'h01;
            4'd9:    s = 8'h09;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    logic [3:0] digit;
    logic [7:0] seg_raw;

    always_comb begin
        case (idx_q)
            2'd0:    digit = min_o_q;
            2'd1:    digit = {1'b0, min_t_q};
            2'd2:    digit = hr_o_q;
            default: digit = {2'b00, hr_t_q};
        endcase
        seg_raw = seg_decode(digit);
    end

    always_comb begin
        ref_d = ref_q;
        idx_d = idx_q;
        if (ref_q == REF_MAX) begin
            ref_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            ref_d = ref_q + RW'(1);
        end

        // Anode and segments are both registered from the same index, so
        // they always change on the same edge.
        an_d        = 4'b1111;
        an_d[idx_q] = 1'b0;
        seg_d       = {seg_raw[7:1], ~((idx_q == 2'd2) && colon_q)};
    end

    assign led7_an_o  = an_q;
    assign led7_seg_o = seg_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            dcnt_q     <= '0;
            pre_q      <= '0;
            sec_t_q    <= 3'd0;
            sec_o_q    <= 4'd0;
            min_t_q    <= 3'd0;
            min_o_q    <= 4'd0;
            hr_t_q     <= 2'd0;
            hr_o_q     <= 4'd0;
            colon_q    <= 1'b1;
            ref_q      <= '0;
            idx_q      <= 2'd0;
            an_q       <= 4'b1111;
            seg_q      <= 8'hFF;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            dcnt_q     <= dcnt_d;
            pre_q      <= pre_d;
            sec_t_q    <= sec_t_d;
            sec_o_q    <= sec_o_d;
            min_t_q    <= min_t_d;
            min_o_q    <= min_o_d;
            hr_t_q     <= hr_t_d;
            hr_o_q     <= hr_o_d;
            colon_q    <= colon_d;
            ref_q      <= ref_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

endmodule

// File: tb/tb_digital_clock_top.sv
// ---------------------------------------------------------------------------
// tb_digital_clock_top
//
// Bench for digital_clock_top with a 10-cycle second, 16-cycle debounce and
// 40-cycle digit refresh. Expected display frames are pushed to exp_q when
// the button stimulus is applied and popped as the scan presents each digit.
// Each queue entry is {dp_care, anode[3:0], seg[7:0]}.
// ---------------------------------------------------------------------------
module tb_digital_clock_top;

    logic       clk_i = 1'b0;
    logic [3:0] btn_i;
    logic [3:0] led7_an_o;
    logic [7:0] led7_seg_o;

    digital_clock_top #(
        .CLK_HZ         (10),
        .DEBOUNCE_CYCLES(16),
        .REFRESH_CYCLES (40)
    ) dut (
        .clk_i     (clk_i),
        .btn_i     (btn_i),
        .led7_an_o (led7_an_o),
        .led7_seg_o(led7_seg_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int cyc_cnt = 0;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [12:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] seg_of(input int d);
        logic [7:0] s;
        case (d)
            0: s = 8'h03;  1: s = 8'h9F;  2: s = 8'h25;  3: s = 8'h0D;
            4: s = 8'h99;  5: s = 8'h49;  6: s = 8'h41;  7: s = 8'h1F;
            8: s = 8'h01;  9: s = 8'h09;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input logic [1:0] m, input int n);
        repeat (n) begin
            btn_i[1:0] = m;
            cyc(27);
            btn_i[1:0] = 2'b00;
            cyc(27);
        end
    endtask

    task automatic push_display(input int hh, input int mm, input bit dp_care);
        exp_q.push_back({1'b1,    4'b1110, seg_of(mm % 10)});
        exp_q.push_back({1'b1,    4'b1101, seg_of(mm / 10)});
        exp_q.push_back({dp_care, 4'b1011, seg_of(hh % 10) & 8'hFE});
        exp_q.push_back({1'b1,    4'b0111, seg_of(hh / 10)});
    endtask

    task automatic wait_an(input logic [3:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk_i);
            if (led7_an_o == a) ok = 1'b1;
        end
    endtask

    task automatic drain_display(input string tag);
        logic [12:0] e;
        logic [7:0]  obs;
        logic [7:0]  ex;
        bit          ok;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_an(e[11:8], ok);
            if (!ok) begin
                check($sformatf("%s an%0h timeout", tag, e[11:8]), {28'd0, led7_an_o}, {28'd0, e[11:8]});
            end else begin
                obs = led7_seg_o;
                ex  = e[7:0];
                if (!e[12]) begin
                    obs[0] = 1'b0;
                    ex[0]  = 1'b0;
                end
                check($sformatf("%s seg@an%0h", tag, e[11:8]), {24'd0, obs}, {24'd0, ex});
            end
        end
    endtask

    task automatic show(input int hh, input int mm, input bit dp_care, input string tag);
        push_display(hh, mm, dp_care);
        drain_display(tag);
    endtask

    task automatic do_reset();
        btn_i[3] = 1'b1;
        cyc(3);
        @(negedge clk_i);
        check("rst an", {28'd0, led7_an_o}, 32'h0000000F);
        check("rst seg", {24'd0, led7_seg_o}, 32'h000000FF);
        #1;
        btn_i[3] = 1'b0;
    endtask

    // Colon toggle spacing, measured on the hour-ones digit while it is lit.
    task automatic check_dp_toggle();
        bit   ok;
        logic prev;
        int   last_chg;
        int   n_chg;
        wait_an(4'b0111, ok);
        wait_an(4'b1011, ok);
        check("dp window found", {31'd0, ok}, 32'd1);
        prev     = led7_seg_o[0];
        last_chg = -1;
        n_chg    = 0;
        for (int i = 1; i < 50 && ok; i++) begin
            @(negedge clk_i);
            if (led7_an_o != 4'b1011) break;
            if (led7_seg_o[0] != prev) begin
                if (last_chg >= 0) check("dp interval", i - last_chg, 32'd10);
                last_chg = i;
                n_chg++;
                prev = led7_seg_o[0];
            end
        end
        check("dp toggles seen", {31'd0, n_chg >= 3}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    int t0;
    bit ok_w;

    initial begin
        btn_i = 4'b1000;
        cyc(2);
        do_reset();

        // First edge after release starts the scan at the minute-ones digit.
        @(posedge clk_i);
        @(negedge clk_i);
        check("first an", {28'd0, led7_an_o}, 32'h0000000E);
        check("first seg", {24'd0, led7_seg_o}, 32'h00000003);
        show(0, 0, 1'b0, "post_reset");

        // Set mode, hours to 23.
        btn_i[2] = 1'b1;
        cyc(30);
        show(0, 0, 1'b1, "set_entry");
        pulse(2'b10, 23);
        show(23, 0, 1'b1, "h23");

        // Reset while set is held, then 23 + 1 hour pulses wrap to 00.
        do_reset();
        cyc(30);
        show(0, 0, 1'b1, "after_rst2");
        pulse(2'b10, 23);
        show(23, 0, 1'b1, "h23_again");
        pulse(2'b10, 1);
        show(0, 0, 1'b1, "h_wrap");

        // Minutes to 59, then wrap with no carry into hours.
        pulse(2'b01, 59);
        show(0, 59, 1'b1, "m59");
        pulse(2'b01, 1);
        show(0, 0, 1'b1, "m_wrap");

        // Glitch shorter than the debounce window.
        btn_i[1] = 1'b1;
        cyc(8);
        btn_i[1] = 1'b0;
        cyc(30);
        show(0, 0, 1'b1, "glitch");

        // Reset before the press is accepted.
        btn_i[0] = 1'b1;
        cyc(10);
        btn_i[3] = 1'b1;
        btn_i[0] = 1'b0;
        cyc(3);
        btn_i[3] = 1'b0;
        cyc(30);
        show(0, 0, 1'b1, "rst_midpress_a");

        // Reset after the press is accepted, button released under reset.
        btn_i[1] = 1'b1;
        cyc(27);
        btn_i[3] = 1'b1;
        btn_i[1] = 1'b0;
        cyc(3);
        btn_i[3] = 1'b0;
        cyc(30);
        show(0, 0, 1'b1, "rst_midpress_b");

        // Simultaneous edges, then minutes up to 23:59.
        pulse(2'b11, 23);
        show(23, 23, 1'b1, "both23");
        pulse(2'b01, 36);
        show(23, 59, 1'b1, "set2359");

        // Run mode: 60 seconds of ticks rolls 23:59 to 00:00.
        btn_i[2] = 1'b0;
        t0 = cyc_cnt;
        cyc(250);
        show(23, 59, 1'b0, "pre_roll");
        ok_w = 1'b0;
        for (int i = 0; i < 2000 && !ok_w; i++) begin
            cyc(1);
            if (cyc_cnt >= t0 + 650) ok_w = 1'b1;
        end
        show(0, 0, 1'b0, "rolled");
        check_dp_toggle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
